// File: rtl/sparc_pkg.sv
// rtl/sparc_pkg.sv - shared encodings for the SPARC-V8 subset control unit
// State enum, mux-select codes, opcodes and instruction field helpers.
package sparc_pkg;

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_FETCH   = 3'd1,
        ST_READ    = 3'd2,
        ST_DECODE  = 3'd3,
        ST_ARITH   = 3'd4,
        ST_WB      = 3'd5,
        ST_PCUPD   = 3'd6,
        ST_UNUSED  = 3'd7
    } state_e;

    localparam logic [1:0] ALUA_PA    = 2'd0;
    localparam logic [1:0] ALUA_PC    = 2'd1;

    localparam logic [2:0] ALUB_PB    = 3'd0;
    localparam logic [2:0] ALUB_EXT   = 3'd1;
    localparam logic [2:0] ALUB_FOUR  = 3'd2;
    localparam logic [2:0] ALUB_ZERO  = 3'd3;

    localparam logic [1:0] PCIN_NPC   = 2'd0;
    localparam logic [1:0] PCIN_ALU   = 2'd1;
    localparam logic [1:0] PCIN_ZERO  = 2'd3;

    localparam logic [1:0] EXT_SIMM13 = 2'd0;

    localparam logic       MDR_SEL_RAM = 1'b0;

    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [5:0] RAM_LDW    = 6'b000000;

    localparam logic [1:0] OP_ARITH   = 2'b10;

    function automatic logic [1:0] ir_op(input logic [31:0] ir);
        return ir[31:30];
    endfunction

    function automatic logic [4:0] ir_rd(input logic [31:0] ir);
        return ir[29:25];
    endfunction

    function automatic logic [5:0] ir_op3(input logic [31:0] ir);
        return ir[24:19];
    endfunction

    function automatic logic [4:0] ir_rs1(input logic [31:0] ir);
        return ir[18:14];
    endfunction

    function automatic logic ir_imm(input logic [31:0] ir);
        return ir[13];
    endfunction

    function automatic logic [4:0] ir_rs2(input logic [31:0] ir);
        return ir[4:0];
    endfunction

endpackage

// File: rtl/sparc_control_unit.sv
// rtl/sparc_control_unit.sv - fetch/decode/execute sequencer for the SPARC-V8 subset datapath
// Moore outputs from state and IR; MFC only steers the next state.
module sparc_control_unit
    import sparc_pkg::*;
(
    input  logic        Clk,
    input  logic        RESET,
    input  logic [31:0] IR_Out,
    input  logic        MFC,
    output logic        NPC_enable,
    output logic        PC_enable,
    output logic        MDR_Enable,
    output logic        MAR_Enable,
    output logic        register_file_enable,
    output logic        RAM_enable,
    output logic        PSR_Enable,
    output logic [1:0]  extender_select,
    output logic [1:0]  PC_In_Mux_select,
    output logic [1:0]  ALUA_Mux_select,
    output logic [2:0]  ALUB_Mux_select,
    output logic        MDR_Mux_select,
    output logic [4:0]  in_PC,
    output logic [4:0]  in_PA,
    output logic [4:0]  in_PB,
    output logic [5:0]  ALU_op,
    output logic [5:0]  RAM_OpCode
);

    state_e state_q;
    state_e state_d;

    logic unused_ir_bits;
    assign unused_ir_bits = ^IR_Out[12:5];

    assign in_PC = ir_rd(IR_Out);
    assign in_PA = ir_rs1(IR_Out);
    assign in_PB = ir_rs2(IR_Out);

    always_ff @(posedge Clk) begin
        if (!RESET) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_RST;
        case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_READ;
            ST_READ:   state_d = MFC ? ST_DECODE : ST_READ;
            ST_DECODE: state_d = (ir_op(IR_Out) == OP_ARITH) ? ST_ARITH : ST_PCUPD;
            ST_ARITH:  state_d = ST_WB;
            ST_WB:     state_d = ST_PCUPD;
            ST_PCUPD:  state_d = ST_FETCH;
            default:   state_d = ST_RST;
        endcase
    end

    always_comb begin
        NPC_enable           = 1'b0;
        PC_enable            = 1'b0;
        MDR_Enable           = 1'b0;
        MAR_Enable           = 1'b0;
        register_file_enable = 1'b0;
        RAM_enable           = 1'b0;
        PSR_Enable           = 1'b0;
        extender_select      = EXT_SIMM13;
        PC_In_Mux_select     = PCIN_NPC;
        ALUA_Mux_select      = ALUA_PA;
        ALUB_Mux_select      = ALUB_PB;
        MDR_Mux_select       = MDR_SEL_RAM;
        ALU_op               = ALU_ADD;
        RAM_OpCode           = RAM_LDW;

        case (state_q)
            ST_RST: begin
                PC_In_Mux_select = PCIN_ZERO;
                PC_enable        = 1'b1;
            end
            ST_FETCH: begin
                ALUA_Mux_select = ALUA_PC;
                ALUB_Mux_select = ALUB_ZERO;
                ALU_op          = ALU_ADD;
                MAR_Enable      = 1'b1;
            end
            ST_READ: begin
                RAM_enable     = 1'b1;
                RAM_OpCode     = RAM_LDW;
                MDR_Mux_select = MDR_SEL_RAM;
                MDR_Enable     = 1'b1;
            end
            // ARITH and WB drive identical ALU controls so ALU_Out is stable at write-back.
            ST_ARITH, ST_WB: begin
                ALUA_Mux_select = ALUA_PA;
                ALUB_Mux_select = ir_imm(IR_Out) ? ALUB_EXT : ALUB_PB;
                extender_select = EXT_SIMM13;
                ALU_op          = ir_op3(IR_Out);
                if (state_q == ST_ARITH) begin
                    PSR_Enable = IR_Out[23];
                end else begin
                    register_file_enable = (ir_rd(IR_Out) != 5'd0);
                end
            end
            ST_PCUPD: begin
                ALUA_Mux_select  = ALUA_PC;
                ALUB_Mux_select  = ALUB_FOUR;
                ALU_op           = ALU_ADD;
                PC_In_Mux_select = PCIN_ALU;
                PC_enable        = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sparc_control_unit.sv
// tb/tb_sparc_control_unit.sv - scoreboard bench for sparc_control_unit
module tb_sparc_control_unit;

    logic        Clk = 1'b0;
    logic        RESET;
    logic [31:0] IR_Out;
    logic        MFC;
    logic        NPC_enable, PC_enable, MDR_Enable, MAR_Enable;
    logic        register_file_enable, RAM_enable, PSR_Enable;
    logic [1:0]  extender_select, PC_In_Mux_select, ALUA_Mux_select;
    logic [2:0]  ALUB_Mux_select;
    logic        MDR_Mux_select;
    logic [4:0]  in_PC, in_PA, in_PB;
    logic [5:0]  ALU_op, RAM_OpCode;

    always #5 Clk = ~Clk;

    sparc_control_unit dut (
        .Clk                  (Clk),
        .RESET                (RESET),
        .IR_Out               (IR_Out),
        .MFC                  (MFC),
        .NPC_enable           (NPC_enable),
        .PC_enable            (PC_enable),
        .MDR_Enable           (MDR_Enable),
        .MAR_Enable           (MAR_Enable),
        .register_file_enable (register_file_enable),
        .RAM_enable           (RAM_enable),
        .PSR_Enable           (PSR_Enable),
        .extender_select      (extender_select),
        .PC_In_Mux_select     (PC_In_Mux_select),
        .ALUA_Mux_select      (ALUA_Mux_select),
        .ALUB_Mux_select      (ALUB_Mux_select),
        .MDR_Mux_select       (MDR_Mux_select),
        .in_PC                (in_PC),
        .in_PA                (in_PA),
        .in_PB                (in_PB),
        .ALU_op               (ALU_op),
        .RAM_OpCode           (RAM_OpCode)
    );

    typedef enum int {P_RST, P_FETCH, P_READ, P_DECODE, P_ARITH, P_WB, P_PCUPD} phase_t;

    typedef struct {
        logic [43:0] vec;
        phase_t      ph;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [43:0] act;
    assign act = {NPC_enable, PC_enable, MDR_Enable, MAR_Enable, register_file_enable,
                  RAM_enable, PSR_Enable, extender_select, PC_In_Mux_select,
                  ALUA_Mux_select, ALUB_Mux_select, MDR_Mux_select,
                  in_PC, in_PA, in_PB, ALU_op, RAM_OpCode};

    // Reference: what each instruction phase must drive, straight from the instruction fields.
    function automatic logic [43:0] model(input phase_t ph, input logic [31:0] ir);
        logic npc = 0, pce = 0, mdre = 0, mare = 0, rfe = 0, rame = 0, psre = 0, mdrm = 0;
        logic [1:0] ext = 0, pcin = 0, alua = 0;
        logic [2:0] alub = 0;
        logic [5:0] aop = 0, rop = 0;
        case (ph)
            P_RST:   begin pcin = 3; pce = 1; end
            P_FETCH: begin alua = 1; alub = 3; mare = 1; end
            P_READ:  begin rame = 1; mdre = 1; end
            P_ARITH: begin alub = ir[13] ? 3'd1 : 3'd0; aop = ir[24:19]; psre = ir[23]; end
            P_WB:    begin alub = ir[13] ? 3'd1 : 3'd0; aop = ir[24:19]; rfe = (ir[29:25] != 0); end
            P_PCUPD: begin alua = 1; alub = 2; pcin = 1; pce = 1; end
            default: begin end
        endcase
        return {npc, pce, mdre, mare, rfe, rame, psre, ext, pcin, alua, alub, mdrm,
                ir[29:25], ir[18:14], ir[4:0], aop, rop};
    endfunction

    exp_t mon_e;
    always @(negedge Clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (act !== mon_e.vec) begin
                errors++;
                $display("FAIL %s ir=%h actual=%h required=%h", mon_e.ph.name(), IR_Out, act, mon_e.vec);
            end
        end
    end

    task automatic step(input phase_t ph);
        exp_t x;
        x.ph  = ph;
        x.vec = model(ph, IR_Out);
        exp_q.push_back(x);
        @(posedge Clk);
        #1;
    endtask

    // mode: 0 normal, 1 reset asserted during WB, 2 reset asserted while waiting in READ
    task automatic run_instr(input logic [31:0] ir, input int wait_cycles, input int mode);
        IR_Out = ir;
        MFC = 1'($urandom);
        step(P_FETCH);
        if (mode == 2) begin
            MFC = 0;
            step(P_READ);
            RESET = 0;
            step(P_READ);
            RESET = 1;
            step(P_RST);
            return;
        end
        repeat (wait_cycles) begin
            MFC = 0;
            step(P_READ);
        end
        MFC = 1;
        step(P_READ);
        MFC = 1'($urandom);
        step(P_DECODE);
        if (ir[31:30] == 2'b10) begin
            MFC = 1'($urandom);
            step(P_ARITH);
            if (mode == 1) RESET = 0;
            MFC = 1'($urandom);
            step(P_WB);
            if (mode == 1) begin
                RESET = 1;
                step(P_RST);
                return;
            end
        end
        MFC = 1'($urandom);
        step(P_PCUPD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] ir;
        RESET  = 0;
        IR_Out = 32'h0;
        MFC    = 0;
        @(posedge Clk); #1;
        step(P_RST);
        RESET = 1;
        step(P_RST);

        run_instr(32'b10_00001_000000_00000_1_0000000000011, 3, 0);
        run_instr(32'b10_00010_000000_00000_1_0000000000110, 0, 0);
        run_instr(32'b10_00010_000000_00001_0_00000000_00010, 1, 0);
        run_instr(32'b10_00000_010000_00001_1_0000000000001, 2, 0);
        run_instr(32'b01_00011_000000_00001_0_00000000_00010, 0, 0);
        run_instr(32'b10_00011_000010_00001_0_00000000_00101, 0, 1);
        run_instr(32'b10_00100_000000_00001_1_0000000000111, 0, 2);

        for (int i = 0; i < 40; i++) begin
            ir = $urandom;
            if ($urandom_range(0, 1) == 1) ir[31:30] = 2'b10;
            run_instr(ir, $urandom_range(0, 4), ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        @(negedge Clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
